// File: rtl/bit_serial_adder.sv
// Bit-serial adder: one full-adder cell and a registered carry, LSB first,
// with a start/done handshake and registered sum, carry-out and overflow.
module bit_serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a, b, r, r_nxt;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             s, co, last;

  // Full-adder cell built from two half adders plus an OR.
  always_comb begin
    s     = a[0] ^ b[0] ^ carry;
    co    = (a[0] & b[0]) | (carry & (a[0] ^ b[0]));
    r_nxt = r >> 1;
    r_nxt[WIDTH-1] = s;
    last  = (cnt == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ADD;
      ADD:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == ADD);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      a     <= '0;
      b     <= '0;
      r     <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      c_out <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          a     <= in1;
          b     <= in2;
          carry <= c_in;
          cnt   <= '0;
        end
        ADD: begin
          a     <= a >> 1;
          b     <= b >> 1;
          r     <= r_nxt;
          carry <= co;
          cnt   <= cnt + CW'(1);
          // Result registers update only on the MSB edge; carry here is the carry into the MSB.
          if (last) begin
            sum   <= r_nxt;
            c_out <= co;
            ovf   <= carry ^ co;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
